// File: rtl/psum_sched_pkg.sv
// Shared types and defaults for the psum tile scheduler.
package psum_sched_pkg;

  // Default downstream buffer depth in indices (initial credit count).
  localparam int CREDIT_MAX_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    ADVANCE,
    FINISH
  } sched_state_t;

endpackage

// File: rtl/psum_credit_counter.sv
// Saturating credit counter that tracks free downstream slots, plus the
// falling-edge await flop that stalls the generator when credits run out.
module psum_credit_counter #(
  parameter int CREDIT_MAX   = 8,
  parameter int CREDIT_WIDTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic consume,
  input  logic credit_return,
  input  logic pause,
  output logic gen_await
);

  localparam logic [CREDIT_WIDTH-1:0] CREDIT_FULL = CREDIT_WIDTH'(CREDIT_MAX);

  logic [CREDIT_WIDTH-1:0] credit_cnt;
  logic                    credit_empty;

  assign credit_empty = (credit_cnt == '0);

  // One credit per emitted index, one back per freed slot; simultaneous
  // consume and return cancel. Holds at 0 and at full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit_cnt <= CREDIT_FULL;
    end else if (consume && !credit_return) begin
      if (!credit_empty) credit_cnt <= credit_cnt - 1'b1;
    end else if (credit_return && !consume) begin
      if (credit_cnt != CREDIT_FULL) credit_cnt <= credit_cnt + 1'b1;
    end
  end

  // Await is refreshed on the generator's advance edge, so an emission that
  // spends the last credit still completes before the stall takes effect.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) gen_await <= 1'b1;
    else       gen_await <= pause | credit_empty;
  end

  // The generator must never emit with no credit left.
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(consume && credit_empty));

endmodule

// File: rtl/psum_tile_scheduler.sv
// Walks a batch-tile x channel-tile grid (channel inner loop), launching the
// psum index generator once per tile with registered base offsets.
module psum_tile_scheduler
  import psum_sched_pkg::*;
#(
  parameter int M_WIDTH      = 10,
  parameter int N_WIDTH      = 3,
  parameter int TILE_WIDTH   = 6,
  parameter int CREDIT_MAX   = CREDIT_MAX_DEFAULT,
  parameter int CREDIT_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [TILE_WIDTH-1:0] cfg_n_tiles,
  input  logic [TILE_WIDTH-1:0] cfg_m_tiles,
  input  logic [N_WIDTH-1:0]    cfg_psum_step,
  input  logic [M_WIDTH-1:0]    cfg_ch_step,
  output logic                  gen_start,
  output logic [N_WIDTH-1:0]    gen_psum_base,
  output logic [M_WIDTH-1:0]    gen_channel_base,
  output logic                  gen_await,
  input  logic                  gen_busy,
  input  logic                  gen_done,
  input  logic                  credit_return,
  input  logic                  pause,
  output logic                  tile_done,
  output logic                  job_done
);

  sched_state_t state_reg, state_next;

  // Last valid index per dimension; a zero tile count behaves as one tile.
  logic [TILE_WIDTH-1:0] n_last_reg, m_last_reg;
  logic [TILE_WIDTH-1:0] n_idx_reg, m_idx_reg;
  logic [N_WIDTH-1:0]    psum_step_reg, psum_base_reg;
  logic [M_WIDTH-1:0]    ch_step_reg, channel_base_reg;
  logic                  m_more, n_more;

  assign m_more           = (m_idx_reg < m_last_reg);
  assign n_more           = (n_idx_reg < n_last_reg);
  assign gen_psum_base    = psum_base_reg;
  assign gen_channel_base = channel_base_reg;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state and handshake/pulse decode.
  always_comb begin
    state_next = state_reg;
    cfg_ready  = 1'b0;
    gen_start  = 1'b0;
    tile_done  = 1'b0;
    job_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) state_next = LAUNCH;
      end
      LAUNCH: begin
        gen_start  = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (gen_done) begin
          tile_done  = 1'b1;
          state_next = ADVANCE;
        end
      end
      ADVANCE: state_next = (m_more || n_more) ? LAUNCH : FINISH;
      FINISH: begin
        job_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Job latch and tile index/base stepping; bases wrap modulo their width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_last_reg       <= '0;
      m_last_reg       <= '0;
      n_idx_reg        <= '0;
      m_idx_reg        <= '0;
      psum_step_reg    <= '0;
      ch_step_reg      <= '0;
      psum_base_reg    <= '0;
      channel_base_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cfg_valid) begin
            n_last_reg       <= (cfg_n_tiles == '0) ? '0 : cfg_n_tiles - 1'b1;
            m_last_reg       <= (cfg_m_tiles == '0) ? '0 : cfg_m_tiles - 1'b1;
            psum_step_reg    <= cfg_psum_step;
            ch_step_reg      <= cfg_ch_step;
            n_idx_reg        <= '0;
            m_idx_reg        <= '0;
            psum_base_reg    <= '0;
            channel_base_reg <= '0;
          end
        end
        ADVANCE: begin
          if (m_more) begin
            m_idx_reg        <= m_idx_reg + 1'b1;
            channel_base_reg <= channel_base_reg + ch_step_reg;
          end else if (n_more) begin
            m_idx_reg        <= '0;
            channel_base_reg <= '0;
            n_idx_reg        <= n_idx_reg + 1'b1;
            psum_base_reg    <= psum_base_reg + psum_step_reg;
          end
        end
        default: ;
      endcase
    end
  end

  psum_credit_counter #(
    .CREDIT_MAX   (CREDIT_MAX),
    .CREDIT_WIDTH (CREDIT_WIDTH)
  ) u_credit (
    .clk           (clk),
    .reset         (reset),
    .consume       (gen_busy),
    .credit_return (credit_return),
    .pause         (pause),
    .gen_await     (gen_await)
  );

endmodule

// File: tb/tb_psum_tile_scheduler.sv
// Scoreboard bench: a behavioural generator/downstream model drives the
// scheduler; expected base pairs are queued at cfg time and popped per start.
module tb_psum_tile_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [5:0] cfg_n_tiles, cfg_m_tiles;
  logic [2:0] cfg_psum_step;
  logic [9:0] cfg_ch_step;
  logic       gen_start;
  logic [2:0] gen_psum_base;
  logic [9:0] gen_channel_base;
  logic       gen_await;
  logic       gen_busy, gen_done, credit_return, pause;
  logic       tile_done, job_done;

  psum_tile_scheduler #(
    .M_WIDTH(10), .N_WIDTH(3), .TILE_WIDTH(6), .CREDIT_MAX(2), .CREDIT_WIDTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_n_tiles(cfg_n_tiles), .cfg_m_tiles(cfg_m_tiles),
    .cfg_psum_step(cfg_psum_step), .cfg_ch_step(cfg_ch_step),
    .gen_start(gen_start), .gen_psum_base(gen_psum_base),
    .gen_channel_base(gen_channel_base), .gen_await(gen_await),
    .gen_busy(gen_busy), .gen_done(gen_done),
    .credit_return(credit_return), .pause(pause),
    .tile_done(tile_done), .job_done(job_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] p;
    logic [9:0] c;
  } pair_t;

  pair_t exp_q[$];
  int total = 0, bad = 0;
  int starts = 0, tiles = 0, jobs = 0, emitted = 0, cyc = 0;
  int last_done_cyc = -1;
  int tile_len = 3;
  int ret_pulses = 0, match_left = 0;
  bit auto_return = 1'b1;
  bit gen_active = 1'b0;
  int gen_left = 0;
  logic [2:0] cur_p;
  logic [9:0] cur_c;

  task automatic chk(input string tag, input int got, input int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, expv);
    end
  endtask

  // Generator + downstream model: acts just after each falling edge, once
  // the await flop has updated.
  always begin
    @(negedge clk); #1;
    gen_busy      = 1'b0;
    gen_done      = 1'b0;
    credit_return = 1'b0;
    if (reset) begin
      gen_active = 1'b0;
      gen_left   = 0;
    end else begin
      if (gen_start) begin
        gen_active = 1'b1;
        gen_left   = tile_len;
      end else if (gen_active) begin
        if (gen_left == 0) begin
          gen_done   = 1'b1;
          gen_active = 1'b0;
        end else if (!gen_await) begin
          gen_busy = 1'b1;
          gen_left--;
          emitted++;
        end
      end
      if (ret_pulses > 0) begin
        credit_return = 1'b1;
        ret_pulses--;
      end else if (gen_busy && (auto_return || match_left > 0)) begin
        credit_return = 1'b1;
        if (match_left > 0) match_left--;
      end
    end
  end

  // Output monitor: scoreboard pops on every start.
  always begin
    @(negedge clk); #2;
    cyc++;
    if (!reset) begin
      if (gen_start) begin
        starts++;
        cur_p = gen_psum_base;
        cur_c = gen_channel_base;
        $display("tile start psum_base=%0d channel_base=%0d", gen_psum_base, gen_channel_base);
        if (exp_q.size() == 0) begin
          chk("unexpected_start", 1, 0);
        end else begin
          pair_t e;
          e = exp_q.pop_front();
          chk("psum_base", gen_psum_base, e.p);
          chk("channel_base", gen_channel_base, e.c);
        end
        if (last_done_cyc >= 0) chk("done_to_start", cyc - last_done_cyc, 2);
      end
      if (tile_done) begin
        tiles++;
        last_done_cyc = cyc;
        chk("psum_hold", gen_psum_base, cur_p);
        chk("ch_hold", gen_channel_base, cur_c);
      end
      if (job_done) begin
        jobs++;
        last_done_cyc = -1;
        $display("job done after %0d tiles", tiles);
      end
    end
  end

  task automatic start_job(input int n, input int m, input int ps, input int cs, input int len);
    int nn, mm;
    pair_t e;
    nn = (n == 0) ? 1 : n;
    mm = (m == 0) ? 1 : m;
    for (int ni = 0; ni < nn; ni++) begin
      for (int mi = 0; mi < mm; mi++) begin
        e.p = 3'(ni * ps);
        e.c = 10'(mi * cs);
        exp_q.push_back(e);
      end
    end
    tile_len = len;
    chk("cfg_ready_idle", cfg_ready, 1);
    cfg_n_tiles   = 6'(n);
    cfg_m_tiles   = 6'(m);
    cfg_psum_step = 3'(ps);
    cfg_ch_step   = 10'(cs);
    cfg_valid     = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    $display("cfg n=%0d m=%0d psum_step=%0d ch_step=%0d len=%0d", n, m, ps, cs, len);
  endtask

  task automatic wait_job(input int budget);
    int j0;
    bit seen;
    j0 = jobs;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (jobs > j0) seen = 1'b1;
    end
    chk("job_done_seen", seen, 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int t0, j0, s0, e0, snap;
    reset = 1'b1; cfg_valid = 1'b0; pause = 1'b0;
    cfg_n_tiles = '0; cfg_m_tiles = '0; cfg_psum_step = '0; cfg_ch_step = '0;
    gen_busy = 1'b0; gen_done = 1'b0; credit_return = 1'b0;
    idle_cycles(3);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_gen_await", gen_await, 1);
    chk("rst_gen_start", gen_start, 0);
    chk("rst_tile_done", tile_done, 0);
    chk("rst_job_done", job_done, 0);
    chk("rst_psum_base", gen_psum_base, 0);
    chk("rst_ch_base", gen_channel_base, 0);
    reset = 1'b0;
    idle_cycles(2);

    // 2x3 grid, balanced credit returns.
    t0 = tiles; j0 = jobs; s0 = starts; e0 = emitted;
    start_job(2, 3, 4, 12, 3);
    wait_job(300);
    chk("a_tiles", tiles - t0, 6);
    chk("a_starts", starts - s0, 6);
    chk("a_jobs", jobs - j0, 1);
    chk("a_emitted", emitted - e0, 18);
    chk("a_queue_empty", exp_q.size(), 0);

    // Zero tile counts behave as a single tile.
    t0 = tiles; j0 = jobs;
    start_job(0, 0, 7, 99, 2);
    wait_job(100);
    chk("b_tiles", tiles - t0, 1);
    chk("b_jobs", jobs - j0, 1);

    // Wrapping bases, and a second cfg while busy must be ignored.
    t0 = tiles; j0 = jobs;
    start_job(3, 2, 5, 1000, 3);
    idle_cycles(2);
    chk("busy_cfg_ready", cfg_ready, 0);
    cfg_n_tiles = 6'd5; cfg_m_tiles = 6'd5; cfg_valid = 1'b1;
    idle_cycles(1);
    cfg_valid = 1'b0;
    wait_job(300);
    chk("c_tiles", tiles - t0, 6);
    chk("c_jobs", jobs - j0, 1);
    chk("c_queue_empty", exp_q.size(), 0);
    idle_cycles(10);
    chk("c_no_extra_job", jobs - j0, 1);

    // Pause during RUN freezes emission; release loses nothing.
    e0 = emitted;
    start_job(1, 1, 0, 0, 6);
    for (int i = 0; i < 50 && (emitted - e0) < 2; i++) idle_cycles(1);
    pause = 1'b1;
    @(negedge clk); #3;
    chk("pause_await", gen_await, 1);
    snap = emitted;
    idle_cycles(6);
    chk("pause_frozen", emitted - snap, 0);
    chk("pause_await_held", gen_await, 1);
    pause = 1'b0;
    wait_job(100);
    chk("pause_total", emitted - e0, 6);

    // Returns at full are ignored; then starve the generator.
    ret_pulses = 2;
    idle_cycles(4);
    auto_return = 1'b0;
    e0 = emitted;
    start_job(1, 1, 0, 0, 8);
    idle_cycles(20);
    chk("starve_emits", emitted - e0, 2);
    chk("starve_await", gen_await, 1);
    ret_pulses = 1;
    idle_cycles(20);
    chk("one_credit_emits", emitted - e0, 3);
    chk("one_credit_await", gen_await, 1);
    // Credit returned alongside an emission at one credit: net unchanged.
    ret_pulses = 1;
    match_left = 1;
    idle_cycles(20);
    chk("same_cycle_emits", emitted - e0, 5);
    chk("same_cycle_await", gen_await, 1);
    auto_return = 1'b1;
    ret_pulses = 2;
    wait_job(100);
    chk("starve_total", emitted - e0, 8);

    // Reset in the middle of RUN.
    auto_return = 1'b0;
    start_job(2, 2, 1, 1, 4);
    idle_cycles(10);
    j0 = jobs;
    reset = 1'b1;
    #1;
    chk("mid_rst_cfg_ready", cfg_ready, 1);
    chk("mid_rst_gen_start", gen_start, 0);
    chk("mid_rst_await", gen_await, 1);
    idle_cycles(2);
    reset = 1'b0;
    exp_q.delete();
    last_done_cyc = -1;
    #1;
    chk("post_rst_await_before_fall", gen_await, 1);
    @(negedge clk); #2;
    chk("post_rst_await_after_fall", gen_await, 0);
    idle_cycles(5);
    chk("post_rst_no_job_done", jobs - j0, 0);
    chk("post_rst_cfg_ready", cfg_ready, 1);
    // Credits restored to full: exactly two emissions without returns.
    e0 = emitted;
    start_job(1, 1, 0, 0, 4);
    idle_cycles(15);
    chk("post_rst_credit_emits", emitted - e0, 2);
    auto_return = 1'b1;
    ret_pulses = 2;
    wait_job(100);
    chk("post_rst_total", emitted - e0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
